// File: rtl/tank_multi_shot_if.sv
// tank_multi_shot_if: bundles the frame strobe, keyboard, pixel probe and tank/bullet status signals.
//   master: drives frame_clk, keycode, DrawX, DrawY; observes the status outputs
//   slave : the tank block; drives is_tank, is_bullet, tank_X, tank_Y, tank_dir,
//           bullet_active, shot_fired, wall_hit
interface tank_multi_shot_if #(
    parameter int NUM_BULLETS = 4
);
    logic                   frame_clk;
    logic [7:0]             keycode;
    logic [9:0]             DrawX;
    logic [9:0]             DrawY;
    logic                   is_tank;
    logic                   is_bullet;
    logic [9:0]             tank_X;
    logic [9:0]             tank_Y;
    logic [2:0]             tank_dir;
    logic [NUM_BULLETS-1:0] bullet_active;
    logic                   shot_fired;
    logic                   wall_hit;

    modport master (
        output frame_clk, keycode, DrawX, DrawY,
        input  is_tank, is_bullet, tank_X, tank_Y, tank_dir, bullet_active, shot_fired, wall_hit
    );

    modport slave (
        input  frame_clk, keycode, DrawX, DrawY,
        output is_tank, is_bullet, tank_X, tank_Y, tank_dir, bullet_active, shot_fired, wall_hit
    );
endinterface

// File: rtl/tank_multi_shot.sv
// tank_multi_shot: keyboard-driven tank with a pool of bullets and a fire cooldown, stepped once per frame tick.
//   Clk   in  system clock
//   Reset in  synchronous, active-high
//   bus   slave modport: frame_clk/keycode/DrawX/DrawY in; is_tank, is_bullet,
//         tank_X, tank_Y, tank_dir, bullet_active, shot_fired, wall_hit out
module tank_multi_shot #(
    parameter int         X_START     = 500,
    parameter int         Y_START     = 240,
    parameter int         SCREEN_W    = 640,
    parameter int         SCREEN_H    = 480,
    parameter int         TANK_SIZE   = 32,
    parameter int         TANK_STEP   = 1,
    parameter int         NUM_BULLETS = 4,
    parameter int         BULLET_SIZE = 8,
    parameter int         BULLET_STEP = 4,
    parameter int         COOLDOWN    = 15,
    parameter logic [7:0] KEY_UP      = 8'h1A,
    parameter logic [7:0] KEY_DOWN    = 8'h16,
    parameter logic [7:0] KEY_LEFT    = 8'h04,
    parameter logic [7:0] KEY_RIGHT   = 8'h07,
    parameter logic [7:0] KEY_FIRE    = 8'h58
) (
    input logic               Clk,
    input logic               Reset,
    tank_multi_shot_if.slave  bus
);
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int IW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam logic [10:0] W     = 11'(SCREEN_W);
    localparam logic [10:0] H     = 11'(SCREEN_H);
    localparam logic [10:0] TS    = 11'(TANK_SIZE);
    localparam logic [10:0] TST   = 11'(TANK_STEP);
    localparam logic [10:0] BS    = 11'(BULLET_SIZE);
    localparam logic [10:0] BST   = 11'(BULLET_STEP);
    localparam logic [9:0]  TS10  = 10'(TANK_SIZE);
    localparam logic [9:0]  BS10  = 10'(BULLET_SIZE);
    localparam logic [9:0]  BST10 = 10'(BULLET_STEP);
    localparam logic [9:0]  C10   = 10'((TANK_SIZE - BULLET_SIZE) / 2);

    typedef enum logic [2:0] {
        DIR_UP    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_t;

    // fsync_q[1:0] synchronise frame_clk; fsync_q[2] holds the previous synced value
    logic [2:0]             fsync_q;
    logic                   tick;
    logic [9:0]             x_q, x_d, y_q, y_d;
    dir_t                   dir_q, dir_d;
    logic [NUM_BULLETS-1:0] act_q, act_d;
    logic [9:0]             bx_q [NUM_BULLETS];
    logic [9:0]             bx_d [NUM_BULLETS];
    logic [9:0]             by_q [NUM_BULLETS];
    logic [9:0]             by_d [NUM_BULLETS];
    dir_t                   bdir_q [NUM_BULLETS];
    dir_t                   bdir_d [NUM_BULLETS];
    logic [CW-1:0]          cd_q, cd_d;
    logic                   fire_prev_q;
    logic                   shot_q, shot_d, hit_q, hit_d;
    logic                   key_up, key_dn, key_lt, key_rt, key_fire;
    logic [10:0]            x11, y11;
    logic [9:0]             mx, my;
    logic                   mok, have_free, px_bullet;
    logic [IW-1:0]          free_idx;

    assign tick     = fsync_q[1] & ~fsync_q[2];
    assign key_up   = bus.keycode == KEY_UP;
    assign key_dn   = bus.keycode == KEY_DOWN;
    assign key_lt   = bus.keycode == KEY_LEFT;
    assign key_rt   = bus.keycode == KEY_RIGHT;
    assign key_fire = bus.keycode == KEY_FIRE;
    assign x11      = {1'b0, x_q};
    assign y11      = {1'b0, y_q};

    // Tank move with clamping; comparisons are done in 11 bits so nothing wraps.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        dir_d = dir_q;
        if (key_up) begin
            y_d   = (y11 < TST) ? 10'd0 : 10'(y11 - TST);
            dir_d = DIR_UP;
        end else if (key_dn) begin
            y_d   = (y11 + TST > H - TS) ? 10'(H - TS) : 10'(y11 + TST);
            dir_d = DIR_DOWN;
        end else if (key_lt) begin
            x_d   = (x11 < TST) ? 10'd0 : 10'(x11 - TST);
            dir_d = DIR_LEFT;
        end else if (key_rt) begin
            x_d   = (x11 + TST > W - TS) ? 10'(W - TS) : 10'(x11 + TST);
            dir_d = DIR_RIGHT;
        end
    end

    // Muzzle position from the post-move tank; mok says the whole bullet fits on screen.
    always_comb begin
        mx  = x_d + C10;
        my  = y_d + C10;
        mok = 1'b0;
        case (dir_d)
            DIR_UP: begin
                my  = y_d - BS10;
                mok = {1'b0, y_d} >= BS;
            end
            DIR_DOWN: begin
                my  = y_d + TS10;
                mok = {1'b0, y_d} + TS + BS <= H;
            end
            DIR_LEFT: begin
                mx  = x_d - BS10;
                mok = {1'b0, x_d} >= BS;
            end
            DIR_RIGHT: begin
                mx  = x_d + TS10;
                mok = {1'b0, x_d} + TS + BS <= W;
            end
            default: mok = 1'b0;
        endcase
    end

    // Lowest free slot, judged on the pre-tick mask so a slot freed this tick stays unavailable.
    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--)
            if (!act_q[i]) begin
                have_free = 1'b1;
                free_idx  = IW'(i);
            end
    end

    // Bullet stepping, despawn at the edges, spawn and cooldown.
    always_comb begin
        act_d  = act_q;
        bx_d   = bx_q;
        by_d   = by_q;
        bdir_d = bdir_q;
        hit_d  = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++)
            if (act_q[i])
                case (bdir_q[i])
                    DIR_UP:
                        if ({1'b0, by_q[i]} < BST) begin
                            act_d[i] = 1'b0;
                            hit_d    = 1'b1;
                        end else
                            by_d[i] = by_q[i] - BST10;
                    DIR_DOWN:
                        if ({1'b0, by_q[i]} + BS + BST > H) begin
                            act_d[i] = 1'b0;
                            hit_d    = 1'b1;
                        end else
                            by_d[i] = by_q[i] + BST10;
                    DIR_LEFT:
                        if ({1'b0, bx_q[i]} < BST) begin
                            act_d[i] = 1'b0;
                            hit_d    = 1'b1;
                        end else
                            bx_d[i] = bx_q[i] - BST10;
                    DIR_RIGHT:
                        if ({1'b0, bx_q[i]} + BS + BST > W) begin
                            act_d[i] = 1'b0;
                            hit_d    = 1'b1;
                        end else
                            bx_d[i] = bx_q[i] + BST10;
                    default: ;
                endcase
        shot_d = key_fire & ~fire_prev_q & (cd_q == '0) & have_free & mok;
        cd_d   = (cd_q != '0) ? cd_q - CW'(1) : cd_q;
        if (shot_d) begin
            act_d[free_idx]  = 1'b1;
            bx_d[free_idx]   = mx;
            by_d[free_idx]   = my;
            bdir_d[free_idx] = dir_d;
            cd_d             = CW'(COOLDOWN);
        end
    end

    always_comb begin
        px_bullet = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++)
            if (act_q[i] && bus.DrawX >= bx_q[i] && {1'b0, bus.DrawX} < {1'b0, bx_q[i]} + BS &&
                bus.DrawY >= by_q[i] && {1'b0, bus.DrawY} < {1'b0, by_q[i]} + BS)
                px_bullet = 1'b1;
    end

    assign bus.is_tank = bus.DrawX >= x_q && {1'b0, bus.DrawX} < x11 + TS &&
                         bus.DrawY >= y_q && {1'b0, bus.DrawY} < y11 + TS;
    assign bus.is_bullet     = px_bullet;
    assign bus.tank_X        = x_q;
    assign bus.tank_Y        = y_q;
    assign bus.tank_dir      = dir_q;
    assign bus.bullet_active = act_q;
    assign bus.shot_fired    = shot_q;
    assign bus.wall_hit      = hit_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fsync_q     <= '0;
            x_q         <= 10'(X_START);
            y_q         <= 10'(Y_START);
            dir_q       <= DIR_UP;
            act_q       <= '0;
            cd_q        <= '0;
            fire_prev_q <= 1'b0;
            shot_q      <= 1'b0;
            hit_q       <= 1'b0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                bx_q[i]   <= '0;
                by_q[i]   <= '0;
                bdir_q[i] <= DIR_UP;
            end
        end else begin
            fsync_q <= {fsync_q[1:0], bus.frame_clk};
            shot_q  <= tick & shot_d;
            hit_q   <= tick & hit_d;
            if (tick) begin
                x_q         <= x_d;
                y_q         <= y_d;
                dir_q       <= dir_d;
                act_q       <= act_d;
                cd_q        <= cd_d;
                fire_prev_q <= key_fire;
                for (int i = 0; i < NUM_BULLETS; i++) begin
                    bx_q[i]   <= bx_d[i];
                    by_q[i]   <= by_d[i];
                    bdir_q[i] <= bdir_d[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_tank_multi_shot.sv
// tb_tank_multi_shot: directed and randomized checks of tank_multi_shot against a behavioural model.
module tb_tank_multi_shot;
    localparam int W = 640, H = 480, TS = 32, BS = 8, BST = 4, CD = 15, NB = 4;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    tank_multi_shot_if #(.NUM_BULLETS(NB)) bus ();
    tank_multi_shot #(.NUM_BULLETS(NB)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    int vectors = 0, miscompares = 0;
    int shot_cnt = 0, hit_cnt = 0;
    int dut_shot, dut_hit;

    always @(negedge Clk) begin
        if (bus.shot_fired === 1'b1) shot_cnt++;
        if (bus.wall_hit === 1'b1) hit_cnt++;
    end

    // behavioural model: positions as signed integers, whole-object on-screen tests
    int tx, ty, td, cd, fp;
    int ba [NB];
    int bx [NB];
    int by [NB];
    int bd [NB];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        tx = 500; ty = 240; td = 1; cd = 0; fp = 0;
        for (int i = 0; i < NB; i++) ba[i] = 0;
    endtask

    task automatic m_tick(input int key, output int es, output int eh);
        int busy [NB];
        int px, py, slot;
        es = 0; eh = 0;
        busy = ba;
        for (int i = 0; i < NB; i++)
            if (ba[i] != 0) begin
                px = bx[i] + ((bd[i] == 2) ? BST : (bd[i] == 3) ? -BST : 0);
                py = by[i] + ((bd[i] == 4) ? BST : (bd[i] == 1) ? -BST : 0);
                if (px < 0 || py < 0 || px + BS > W || py + BS > H) begin
                    ba[i] = 0; eh = 1;
                end else begin
                    bx[i] = px; by[i] = py;
                end
            end
        case (key)
            'h1A: begin td = 1; ty = (ty - 1 < 0) ? 0 : ty - 1; end
            'h16: begin td = 4; ty = (ty + 1 > H - TS) ? H - TS : ty + 1; end
            'h04: begin td = 3; tx = (tx - 1 < 0) ? 0 : tx - 1; end
            'h07: begin td = 2; tx = (tx + 1 > W - TS) ? W - TS : tx + 1; end
            default: ;
        endcase
        slot = -1;
        for (int i = NB - 1; i >= 0; i--) if (busy[i] == 0) slot = i;
        if (key == 'h58 && fp == 0 && cd == 0 && slot >= 0) begin
            px = (td == 1 || td == 4) ? tx + (TS - BS) / 2 : (td == 3) ? tx - BS : tx + TS;
            py = (td == 2 || td == 3) ? ty + (TS - BS) / 2 : (td == 1) ? ty - BS : ty + TS;
            if (px >= 0 && py >= 0 && px + BS <= W && py + BS <= H) begin
                ba[slot] = 1; bx[slot] = px; by[slot] = py; bd[slot] = td; es = 1;
            end
        end
        if (es != 0) cd = CD; else if (cd > 0) cd--;
        fp = (key == 'h58);
    endtask

    function automatic logic [NB-1:0] m_mask();
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) m[i] = ba[i] != 0;
        return m;
    endfunction

    function automatic logic m_tank(input int x, input int y);
        return x >= tx && x < tx + TS && y >= ty && y < ty + TS;
    endfunction

    function automatic logic m_bul(input int x, input int y);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NB; i++)
            if (ba[i] != 0 && x >= bx[i] && x < bx[i] + BS && y >= by[i] && y < by[i] + BS) r = 1'b1;
        return r;
    endfunction

    task automatic probe(input int x, input int y);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        #1;
        check("is_tank", bus.is_tank, m_tank(x, y));
        check("is_bullet", bus.is_bullet, m_bul(x, y));
    endtask

    task automatic step(input logic [7:0] key);
        int es, eh, s0, h0, b;
        s0 = shot_cnt;
        h0 = hit_cnt;
        @(negedge Clk);
        bus.keycode   = key;
        bus.frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        bus.frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        m_tick(int'(key), es, eh);
        dut_shot = shot_cnt - s0;
        dut_hit  = hit_cnt - h0;
        check("tank_X", bus.tank_X, tx);
        check("tank_Y", bus.tank_Y, ty);
        check("tank_dir", bus.tank_dir, td);
        check("bullet_active", bus.bullet_active, m_mask());
        check("shot_fired", dut_shot, es);
        check("wall_hit", dut_hit, eh);
        probe($urandom_range(0, W - 1), $urandom_range(0, H - 1));
        probe(tx + TS - 1, ty + TS - 1);
        probe(tx + TS, ty);
        b = -1;
        for (int i = NB - 1; i >= 0; i--) if (ba[i] != 0) b = i;
        if (b >= 0) probe(bx[b] + BS - 1, by[b] + BS - 1);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset         = 1'b1;
        bus.keycode   = 8'h00;
        bus.frame_clk = 1'b0;
        @(negedge Clk);
        m_reset();
        check("rst_mask", bus.bullet_active, m_mask());
        check("rst_X", bus.tank_X, tx);
        check("rst_Y", bus.tank_Y, ty);
        check("rst_dir", bus.tank_dir, td);
        check("rst_shot", bus.shot_fired, 0);
        check("rst_hit", bus.wall_hit, 0);
        Reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, prev;
        logic [7:0] keys [8];
        keys = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h58, 8'h58, 8'h00};
        Reset = 1'b1;
        bus.frame_clk = 1'b0;
        bus.keycode = 8'h00;
        bus.DrawX = '0;
        bus.DrawY = '0;
        repeat (3) @(negedge Clk);
        do_reset();

        // right for 10 ticks
        repeat (10) step(8'h07);
        check("t1_X", bus.tank_X, 510);
        check("t1_Y", bus.tank_Y, 240);
        check("t1_dir", bus.tank_dir, 2);

        // right clamp at W-TS, then left clamp at 0 with dir still updating
        repeat (103) step(8'h07);
        check("t2_Xmax", bus.tank_X, 608);
        repeat (610) step(8'h04);
        check("t2_Xmin", bus.tank_X, 0);
        check("t2_dir", bus.tank_dir, 3);
        step(8'h58);
        check("t2_offscreen_shot", dut_shot, 0);

        // single shot up, travels to Y=0 then despawns
        do_reset();
        step(8'h58);
        check("t3_shot", dut_shot, 1);
        probe(512, 232);
        check("t3_px_in", bus.is_bullet, 1);
        probe(511, 232);
        check("t3_px_left", bus.is_bullet, 0);
        probe(520, 239);
        check("t3_px_right", bus.is_bullet, 0);
        repeat (58) step(8'h00);
        probe(512, 0);
        check("t3_px_top", bus.is_bullet, 1);
        step(8'h00);
        check("t3_hit", dut_hit, 1);
        check("t3_mask", bus.bullet_active, 0);

        // held fire gives one shot; taps are spaced by the cooldown
        do_reset();
        n = 0;
        repeat (40) begin step(8'h58); n += dut_shot; end
        check("t4_hold_shots", n, 1);
        do_reset();
        prev = -1;
        for (int k = 0; k < 40; k++) begin
            step((k % 2 == 0) ? 8'h58 : 8'h00);
            if (dut_shot != 0) begin
                if (prev >= 0) check("t4_gap", k - prev, 16);
                prev = k;
            end
        end

        // fill all slots from the bottom, drop the 5th, reuse slot 0 after it despawns
        do_reset();
        repeat (208) step(8'h16);
        step(8'h1A);
        n = 0;
        for (int k = 0; k < 112; k++) begin
            step((k % 2 == 0) ? 8'h58 : 8'h00);
            n += dut_shot;
            if (k == 69) begin
                check("t5_full_mask", bus.bullet_active, 4'hF);
                check("t5_shots", n, 4);
            end
        end
        check("t5_freed_mask", bus.bullet_active, 4'hE);
        step(8'h58);
        check("t5_reuse_shot", dut_shot, 1);
        check("t5_reuse_mask", bus.bullet_active, 4'hF);

        // reset with bullets in flight
        do_reset();
        check("t6_mask", bus.bullet_active, 0);

        // randomized play
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else if ($urandom_range(0, 9) == 0) step(8'($urandom_range(0, 255)));
            else step(keys[$urandom_range(0, 7)]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
